// File: rtl/util_tdd_sync_ctrl.sv
// TDD sync sequencer: issues 1-cycle sync_trigger strobes from an internal
// period counter or from qualified rising edges of ext_sync_in, counts frames,
// stops after an optional burst and flags edges dropped during holdoff.
module util_tdd_sync_ctrl #(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned HOLD_W   = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [HOLD_W-1:0]   holdoff,
  input  logic [CNT_W-1:0]    burst_len,
  input  logic                ext_sync_in,
  output logic                sync_trigger,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic                missed_sync
);

  typedef enum logic [2:0] {StIdle, StArm, StRun, StHold, StDone} state_e;

  state_e              state_q, state_d;
  logic                ext_q;
  logic                mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    burst_q, burst_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    frame_q, frame_d;
  logic                trig_q, trig_d;
  logic                miss_q, miss_d;

  logic                sync_edge;
  logic                burst_hit;
  logic [PERIOD_W-1:0] period_eff;

  assign sync_edge  = ext_sync_in & ~ext_q;
  // The frame just strobed was the last one of a finite burst.
  assign burst_hit  = (burst_q != '0) && (frame_q == burst_q);
  // Periods below 2 would give back-to-back strobes; clamp to 2.
  assign period_eff = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      ext_q    <= 1'b0;
      mode_q   <= 1'b0;
      period_q <= '0;
      hold_q   <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      frame_q  <= '0;
      trig_q   <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ext_q    <= ext_sync_in;
      mode_q   <= mode_d;
      period_q <= period_d;
      hold_q   <= hold_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      trig_q   <= trig_d;
      miss_q   <= miss_d;
    end
  end

  // Next-state, trigger decision and counter updates.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    hold_d   = hold_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    trig_d   = 1'b0;
    miss_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StArm;
          mode_d   = mode;
          period_d = period_eff;
          hold_d   = holdoff;
          burst_d  = burst_len;
          cnt_d    = '0;
          frame_d  = '0;
        end
      end
      StArm: begin
        state_d = StRun;
        // Internal mode strobes in the first RUN cycle and starts the period.
        if (!mode_q) begin
          trig_d = 1'b1;
          cnt_d  = period_q - PERIOD_W'(1);
        end
      end
      StRun: begin
        if (trig_q && burst_hit) begin
          state_d = StDone;
        end else if (!mode_q) begin
          if (cnt_q == '0) begin
            trig_d = 1'b1;
            cnt_d  = period_q - PERIOD_W'(1);
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
        end else if (sync_edge) begin
          trig_d = 1'b1;
          if (hold_q != '0) state_d = StHold;
        end
      end
      StHold: begin
        if (trig_q && burst_hit) begin
          state_d = StDone;
        end else begin
          miss_d = sync_edge;
          // Holdoff window starts the cycle after the strobe.
          if (trig_q) begin
            cnt_d = PERIOD_W'(hold_q) - PERIOD_W'(1);
          end else if (cnt_q == '0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - PERIOD_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Dropping enable aborts from any state and suppresses a coincident strobe.
    if (!enable) begin
      state_d = StIdle;
      trig_d  = 1'b0;
      miss_d  = 1'b0;
    end

    if (trig_d) frame_d = frame_q + CNT_W'(1);
  end

  // Outputs decoded from state and registered strobes.
  always_comb begin
    busy         = (state_q == StArm) || (state_q == StRun) || (state_q == StHold);
    done         = (state_q == StDone);
    sync_trigger = trig_q;
    missed_sync  = miss_q;
    frame_cnt    = frame_q;
  end

endmodule
